// File: rtl/lpc_cycle_capture_fifo_if.sv
// Wishbone slave bus between the AHB-to-FPGA bridge and the LPC cycle capture FIFO.
// Signal names keep the bridge's naming, so _i/_o are as seen from the slave.
interface lpc_cycle_capture_fifo_if;
  logic [16:0] WBs_ADR_i;
  logic        WBs_CYC_i;
  logic        WBs_STB_i;
  logic        WBs_WE_i;
  logic [3:0]  WBs_BYTE_STB_i;
  logic [31:0] WBs_DAT_i;
  logic [31:0] WBs_DAT_o;
  logic        WBs_ACK_o;

  modport master (
    output WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_BYTE_STB_i, WBs_DAT_i,
    input  WBs_DAT_o, WBs_ACK_o
  );

  modport slave (
    input  WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_BYTE_STB_i, WBs_DAT_i,
    output WBs_DAT_o, WBs_ACK_o
  );
endinterface

// File: rtl/lpc_cycle_capture_fifo.sv
// LPC cycle capture FIFO drained by the MCU over Wishbone, with threshold/overflow
// level interrupt and a response byte register returned to the LPC side.
module lpc_cycle_capture_fifo #(
  parameter int          DATA_WIDTH        = 32,
  parameter int          DEPTH_LOG2        = 3,
  parameter int          ADDRWIDTH         = 10,
  parameter logic [31:0] DEFAULT_REG_VALUE = 32'hDEF_FAB_AC
) (
  input  logic                    WBs_CLK_i,
  input  logic                    WBs_RST_n_i,
  lpc_cycle_capture_fifo_if.slave wb,
  input  logic [DATA_WIDTH-1:0]   cyc_data_i,
  input  logic                    cyc_valid_i,
  output logic [7:0]              rd_data_o,
  output logic                    rd_data_valid_o,
  input  logic                    rd_data_taken_i,
  output logic                    irq_o
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  localparam logic [ADDRWIDTH-3:0] OFF_DATA   = 0;
  localparam logic [ADDRWIDTH-3:0] OFF_STATUS = 1;
  localparam logic [ADDRWIDTH-3:0] OFF_CTRL   = 2;
  localparam logic [ADDRWIDTH-3:0] OFF_RESP   = 3;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  irq_en_q, irq_en_d, ovf_irq_en_q, ovf_irq_en_d;
  logic [7:0]            thr_q, thr_d;
  logic [7:0]            rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  irq_q, irq_d;
  logic                  ack_q;

  logic [ADDRWIDTH-3:0]  offset;
  logic                  access, wr_access, rd_access;
  logic                  empty, full, push, pop;
  logic [DEPTH_LOG2:0]   thr_eff;
  logic [31:0]           head_word, status_word, ctrl_word, resp_word;

  assign offset    = wb.WBs_ADR_i[ADDRWIDTH-1:2];
  // Writes and pops share the ACK qualifier so each access commits exactly once.
  assign access    = wb.WBs_CYC_i & wb.WBs_STB_i & ~ack_q;
  assign wr_access = access & wb.WBs_WE_i;
  assign rd_access = access & ~wb.WBs_WE_i;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_FULL);

  // NOTE: every variable driven here gets a default first, so no path leaves it
  // holding its old value and no latch is inferred.
  always_comb begin
    pop          = rd_access && (offset == OFF_DATA) && !empty;
    push         = cyc_valid_i && (!full || pop);
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    irq_en_d     = irq_en_q;
    ovf_irq_en_d = ovf_irq_en_q;
    thr_d        = thr_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = rd_valid_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (wr_access && (offset == OFF_STATUS) && wb.WBs_BYTE_STB_i[2] && wb.WBs_DAT_i[18])
      ovf_d = 1'b0;
    // A dropped word outranks a simultaneous clear so no loss goes unreported.
    if (cyc_valid_i && full && !pop)
      ovf_d = 1'b1;

    if (wr_access && (offset == OFF_CTRL)) begin
      if (wb.WBs_BYTE_STB_i[0]) {ovf_irq_en_d, irq_en_d} = wb.WBs_DAT_i[1:0];
      if (wb.WBs_BYTE_STB_i[1]) thr_d = wb.WBs_DAT_i[15:8];
    end

    if (wr_access && (offset == OFF_RESP) && wb.WBs_BYTE_STB_i[0]) begin
      rd_data_d  = wb.WBs_DAT_i[7:0];
      rd_valid_d = 1'b1;
    end else if (rd_data_taken_i) begin
      rd_valid_d = 1'b0;
    end

    thr_eff = thr_q[DEPTH_LOG2:0];
    if (thr_eff == '0) thr_eff = CNT_ONE;
    irq_d = (irq_en_q && (count_q >= thr_eff)) || (ovf_irq_en_q && ovf_q);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
    if (!WBs_RST_n_i) begin
      ack_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      irq_en_q     <= 1'b1;
      ovf_irq_en_q <= 1'b0;
      thr_q        <= 8'h01;
      rd_data_q    <= 8'h00;
      rd_valid_q   <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      ack_q        <= access;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      irq_en_q     <= irq_en_d;
      ovf_irq_en_q <= ovf_irq_en_d;
      thr_q        <= thr_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      irq_q        <= irq_d;
    end
  end

  // NOTE: the storage array has no reset; the count gates every read, so stale
  // entries are never visible and the array can map onto plain RAM/LUT storage.
  always_ff @(posedge WBs_CLK_i) begin
    if (push) mem_q[wr_ptr_q] <= cyc_data_i;
  end

  always_comb begin
    head_word = '0;
    if (!empty) head_word[DATA_WIDTH-1:0] = mem_q[rd_ptr_q];

    status_word                 = '0;
    status_word[DEPTH_LOG2:0]   = count_q;
    status_word[16]             = empty;
    status_word[17]             = full;
    status_word[18]             = ovf_q;
    status_word[19]             = rd_valid_q;

    ctrl_word        = '0;
    ctrl_word[0]     = irq_en_q;
    ctrl_word[1]     = ovf_irq_en_q;
    ctrl_word[15:8]  = thr_q;

    resp_word        = {23'b0, rd_valid_q, rd_data_q};

    case (offset)
      OFF_DATA:   wb.WBs_DAT_o = head_word;
      OFF_STATUS: wb.WBs_DAT_o = status_word;
      OFF_CTRL:   wb.WBs_DAT_o = ctrl_word;
      OFF_RESP:   wb.WBs_DAT_o = resp_word;
      default:    wb.WBs_DAT_o = DEFAULT_REG_VALUE;
    endcase
  end

  assign wb.WBs_ACK_o    = ack_q;
  assign rd_data_o       = rd_data_q;
  assign rd_data_valid_o = rd_valid_q;
  assign irq_o           = irq_q;

  logic unused_bits;
  assign unused_bits = ^{wb.WBs_ADR_i[16:ADDRWIDTH], wb.WBs_ADR_i[1:0],
                         wb.WBs_DAT_i[31:19], wb.WBs_DAT_i[17:16]};
endmodule

// File: tb/tb_lpc_cycle_capture_fifo.sv
// Self-checking bench: directed scenarios followed by random traffic, all compared
// against a queue-based model of the FIFO and its register map.
module tb_lpc_cycle_capture_fifo;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cyc_data = '0;
  logic        cyc_valid = 1'b0;
  logic        taken = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        irq;

  lpc_cycle_capture_fifo_if bus ();

  lpc_cycle_capture_fifo dut (
    .WBs_CLK_i       (clk),
    .WBs_RST_n_i     (rst_n),
    .wb              (bus.slave),
    .cyc_data_i      (cyc_data),
    .cyc_valid_i     (cyc_valid),
    .rd_data_o       (rd_data),
    .rd_data_valid_o (rd_valid),
    .rd_data_taken_i (taken),
    .irq_o           (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, registers as plain fields.
  logic [31:0] mq[$];
  bit          m_ovf, m_irq_en, m_ovf_en, m_rdv;
  logic [7:0]  m_thr, m_rd;

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_irq_en = 1; m_ovf_en = 0; m_thr = 8'h01; m_rd = 8'h00; m_rdv = 0;
  endtask

  function automatic bit m_irq();
    int t = int'(m_thr[3:0]);
    if (t == 0) t = 1;
    return (m_irq_en && mq.size() >= t) || (m_ovf_en && m_ovf);
  endfunction

  function automatic logic [31:0] m_status();
    return {12'h0, m_rdv, m_ovf, mq.size() == DEPTH, mq.size() == 0, 16'(mq.size())};
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] off);
    case (off)
      8'd0:    return (mq.size() > 0) ? mq[0] : 32'h0;
      8'd1:    return m_status();
      8'd2:    return {16'h0, m_thr, 6'h0, m_ovf_en, m_irq_en};
      8'd3:    return {23'h0, m_rdv, m_rd};
      default: return 32'hDEFFABAC;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One Wishbone access, optionally with a concurrent push and taken strobe.
  task automatic wb_access(input bit we, input logic [16:0] adr, input logic [31:0] wdat,
                           input logic [3:0] be, input bit push, input logic [31:0] pdat,
                           input bit tk, output logic [31:0] rdat);
    logic [31:0] exp;
    logic [7:0]  off;
    bit          popped, was_full;
    off = adr[9:2];
    exp = m_read(off);
    bus.WBs_ADR_i = adr; bus.WBs_WE_i = we; bus.WBs_DAT_i = wdat; bus.WBs_BYTE_STB_i = be;
    bus.WBs_CYC_i = 1'b1; bus.WBs_STB_i = 1'b1;
    cyc_valid = push; cyc_data = pdat; taken = tk;
    @(negedge clk);
    rdat = bus.WBs_DAT_o;
    if (!we) check($sformatf("read_%0h", off), rdat, exp);
    @(posedge clk); #1;
    check("ack_high", {31'h0, bus.WBs_ACK_o}, 32'h1);
    bus.WBs_CYC_i = 1'b0; bus.WBs_STB_i = 1'b0; bus.WBs_WE_i = 1'b0;
    cyc_valid = 1'b0; taken = 1'b0;

    popped   = !we && off == 8'd0 && mq.size() > 0;
    was_full = mq.size() == DEPTH;
    if (popped) void'(mq.pop_front());
    if (we && off == 8'd1 && be[2] && wdat[18]) m_ovf = 0;
    if (we && off == 8'd2) begin
      if (be[0]) {m_ovf_en, m_irq_en} = wdat[1:0];
      if (be[1]) m_thr = wdat[15:8];
    end
    if (we && off == 8'd3 && be[0]) begin
      m_rd = wdat[7:0]; m_rdv = 1;
    end else if (tk) m_rdv = 0;
    if (push) begin
      if (!was_full || popped) mq.push_back(pdat);
      else m_ovf = 1;
    end

    @(posedge clk); #1;
    check("ack_low", {31'h0, bus.WBs_ACK_o}, 32'h0);
    check("irq", {31'h0, irq}, {31'h0, m_irq()});
    check("resp_out", {23'h0, rd_valid, rd_data}, {23'h0, m_rdv, m_rd});
  endtask

  task automatic wb_read(input logic [16:0] adr);
    logic [31:0] d;
    wb_access(1'b0, adr, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, d);
  endtask

  task automatic wb_write(input logic [16:0] adr, input logic [31:0] wdat, input logic [3:0] be);
    logic [31:0] d;
    wb_access(1'b1, adr, wdat, be, 1'b0, 32'h0, 1'b0, d);
  endtask

  task automatic push_word(input logic [31:0] d);
    cyc_valid = 1'b1; cyc_data = d;
    @(posedge clk); #1;
    cyc_valid = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(d);
    else m_ovf = 1;
  endtask

  task automatic take_strobe();
    taken = 1'b1;
    @(posedge clk); #1;
    taken = 1'b0;
    m_rdv = 0;
  endtask

  task automatic check_irq(input string tag);
    idle(1);
    check(tag, {31'h0, irq}, {31'h0, m_irq()});
  endtask

  task automatic drain();
    while (mq.size() > 0) wb_read(17'h000);
  endtask

  initial begin
    logic [31:0] d;
    bus.WBs_ADR_i = '0; bus.WBs_CYC_i = 1'b0; bus.WBs_STB_i = 1'b0; bus.WBs_WE_i = 1'b0;
    bus.WBs_BYTE_STB_i = '0; bus.WBs_DAT_i = '0;
    model_reset();

    // Reset values
    idle(3);
    check("rst_ack", {31'h0, bus.WBs_ACK_o}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_resp", {23'h0, rd_valid, rd_data}, 32'h0);
    rst_n = 1'b1;
    idle(1);
    wb_read(17'h004);
    wb_read(17'h008);
    wb_read(17'h010);

    // Basic ordering and irq latency
    push_word(32'h11);
    check("irq_latency0", {31'h0, irq}, 32'h0);
    idle(1);
    check("irq_latency1", {31'h0, irq}, 32'h1);
    push_word(32'h22);
    push_word(32'h33);
    idle(1);
    repeat (4) wb_read(17'h000);
    wb_read(17'h004);

    // Overflow with nine pushes, then clear
    for (int i = 0; i < 9; i++) push_word(32'hA0 + i);
    idle(1);
    wb_read(17'h004);
    check("ovf_status", m_status(), 32'h0006_0008);
    wb_write(17'h004, 32'h0004_0000, 4'b0100);
    wb_read(17'h004);
    drain();

    // Push during the commit cycle of a read while full
    for (int i = 0; i < 8; i++) push_word(32'h40 + i);
    idle(1);
    wb_access(1'b0, 17'h000, 32'h0, 4'h0, 1'b1, 32'h99, 1'b0, d);
    wb_read(17'h004);
    drain();

    // Threshold 4
    wb_write(17'h008, 32'h0000_0401, 4'b0011);
    for (int i = 0; i < 3; i++) push_word(32'h70 + i);
    check_irq("thr_below");
    push_word(32'h73);
    check_irq("thr_reached");
    drain();

    // Response register
    wb_write(17'h00C, 32'hA5, 4'b0001);
    wb_access(1'b1, 17'h00C, 32'h5A, 4'b0001, 1'b0, 32'h0, 1'b1, d);
    take_strobe();
    check("resp_taken", {23'h0, rd_valid, rd_data}, {23'h0, m_rdv, m_rd});
    wb_read(17'h00C);

    // Random traffic
    for (int it = 0; it < 400; it++) begin
      int op = $urandom_range(0, 11);
      case (op)
        0, 1, 2, 3: push_word($urandom);
        4, 5: wb_access(1'b0, {7'($urandom), 8'd0, 2'($urandom)}, 32'h0, 4'h0,
                        1'($urandom), $urandom, 1'b0, d);
        6: wb_read({7'($urandom), 8'($urandom_range(0, 5)), 2'($urandom)});
        7: wb_write(17'h008, $urandom, 4'($urandom));
        8: wb_write(17'h004, $urandom, 4'($urandom));
        9: wb_access(1'b1, 17'h00C, $urandom, 4'($urandom), 1'b0, 32'h0, 1'($urandom), d);
        10: take_strobe();
        default: idle(1);
      endcase
      check_irq("rand_irq");
    end

    // Reset in the middle of an access
    push_word(32'hBEEF);
    @(posedge clk); #1;
    bus.WBs_ADR_i = 17'h000; bus.WBs_WE_i = 1'b0; bus.WBs_CYC_i = 1'b1; bus.WBs_STB_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_ack", {31'h0, bus.WBs_ACK_o}, 32'h0);
    check("midrst_irq", {31'h0, irq}, 32'h0);
    bus.WBs_CYC_i = 1'b0; bus.WBs_STB_i = 1'b0;
    rst_n = 1'b1;
    model_reset();
    idle(1);
    wb_read(17'h004);
    wb_read(17'h008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lpc_cycle_capture_fifo.md
# lpc_cycle_capture_fifo

Parametrised successor to the single-register LPC capture path: buffers LPC cycle words (address/data/type packed by the LPC peripheral) in a DEPTH-entry FIFO in the Wishbone clock domain instead of overwriting one register. The MCU drains the FIFO over the AHB-to-FPGA Wishbone bridge. A level interrupt with programmable threshold and a sticky overflow flag replace the one-cycle interrupt pulse. A response register returns read data to the LPC side for host read cycles.

## Interface
- DATA_WIDTH, 32: width of a captured cycle word (≤32).
- DEPTH_LOG2, 3: FIFO depth = 2**DEPTH_LOG2 (8).
- ADDRWIDTH, 10: decoded Wishbone address bits; registers at word offsets 0x000/0x004/0x008/0x00C.
- DEFAULT_REG_VALUE, 32'hDEF_FAB_AC: read value of unimplemented offsets.
- WBs_CLK_i  in  1  single clock (Wishbone, 80 MHz); all logic on rising edge.
- WBs_RST_n_i  in  1  reset, asynchronous assert, active-low.
- WBs_ADR_i  in  17  address; bits [ADDRWIDTH-1:2] decoded.
- WBs_CYC_i, WBs_STB_i, WBs_WE_i  in  1 each  Wishbone cycle, strobe, write enable.
- WBs_BYTE_STB_i  in  4  byte lanes for writes.
- WBs_DAT_i  in  32  write data.
- WBs_DAT_o  out  32  read data, combinational from address.
- WBs_ACK_o  out  1  registered acknowledge.
- cyc_data_i  in  DATA_WIDTH  captured LPC cycle word, already in WBs_CLK_i domain.
- cyc_valid_i  in  1  one-cycle push strobe for cyc_data_i.
- rd_data_o  out  8  response byte for host read cycles.
- rd_data_valid_o  out  1  rd_data_o holds an unconsumed response.
- rd_data_taken_i  in  1  one-cycle strobe; LPC side consumed rd_data_o.
- irq_o  out  1  level interrupt to MCU.

## Operation
- Reset values: WBs_ACK_o=0, irq_o=0, rd_data_o=0, rd_data_valid_o=0, FIFO empty (count=0, pointers 0), overflow=0, CONTROL=0x0000_0101.
- ACK: next = CYC & STB & ~ACK; every access acked exactly one cycle after it begins, including unimplemented offsets.
- A write or pop commits on the edge where CYC & STB & ~ACK (same qualifier as ACK).
- 0x000 FIFO_DATA (RO): reads zero-extended head entry; read access pops one entry; empty read returns 0, no pop, no pointer change. Writes ignored.
- 0x004 STATUS: [DEPTH_LOG2:0] count, [16] empty, [17] full, [18] overflow (sticky), [19] rd_data_valid_o. Write with byte lane 2 and bit 18 = 1 clears overflow; other bits RO.
- 0x008 CONTROL (RW, byte-laned): [0] irq_en, [1] ovf_irq_en, [15:8] threshold (low DEPTH_LOG2+1 bits used; 0 treated as 1); other bits read 0.
- 0x00C RESP_DATA: write with lane 0 loads rd_data_o and sets rd_data_valid_o; read returns {23'b0, rd_data_valid_o, rd_data_o}.
- Push: cyc_valid_i & ~full writes at tail, tail wraps modulo depth.
- Push when full with no pop in the same cycle: word dropped, overflow set, FIFO contents unchanged.
- Push and pop in the same cycle: both performed, count unchanged, even when full.
- Push while empty with pop requested: pop ignored, push performed, count 1.
- rd_data_valid_o clears on rd_data_taken_i. RESP_DATA write in the same cycle as taken: write wins, valid stays 1 with new data.
- irq_o (registered) = (irq_en & count ≥ threshold) | (ovf_irq_en & overflow). Level; clears only when draining or overflow clear removes the cause.

## Timing
- Push on edge t: count/STATUS/head visible after t; irq_o reflects it after edge t+1 (one-cycle latency).
- Pop: DAT_o shows head during access cycle; pointer advances on the commit edge, so the next access sees the following entry.
- Reset assertion mid-transfer: immediate clear of all state; an in-flight access receives no ACK.
- Full flag reads 1 at count = 2**DEPTH_LOG2; pointer width DEPTH_LOG2, count width DEPTH_LOG2+1.

## Test plan
- Reset, read 0x004 -> 0x0001_0000; read 0x008 -> 0x0000_0101; irq_o=0; read 0x010 -> 0xDEFFABAC.
- Push 0x11,0x22,0x33, read 0x000 three times -> 0x11,0x22,0x33, then read -> 0, STATUS count 0; irq_o high 2 cycles after first push, low 1 cycle after final pop.
- Push 9 words (depth 8) -> STATUS 0x0006_0008, 9th word lost, reads return first 8 in order; write 0x0004_0000 to 0x004 -> overflow cleared.
- FIFO full, cyc_valid_i=1 in the commit cycle of a FIFO_DATA read -> count stays 8, overflow 0, new word becomes last entry.
- CONTROL=0x0000_0401 (threshold 4): 3 pushes -> irq_o 0; 4th push -> irq_o 1.
- Write 0xA5 to 0x00C -> rd_data_o=0xA5, valid=1; rd_data_taken_i with concurrent write 0x5A -> valid 1, data 0x5A; lone taken -> valid 0.
